fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the decoder and control FSM. It generates sequential word addresses, fetches words from instruction memory over a single-outstanding req/ack handshake, and buffers them in a small prefetch queue. It presents the head instruction, pre-split into op/funct/rd/cond fields, to the decoder under a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new PC when a branch is taken or PC is written.

---
 rtl/fetch_queue.sv | 160 ++++++++++++++++
 tb/tb_fetch_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch: sequential word fetch over req/ack, DEPTH-entry prefetch queue, head split into decoder fields.
// Latency: a word acked in cycle N is at the head in cycle N+1; sustains 1 word/cycle with ack held high.
// Backpressure: stops requesting while every slot is full or reserved; head uses instr_valid/instr_ready.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state;
    state_t        nxt_state;
    logic [31:0]   fetch_pc;
    logic [31:0]   nxt_pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_upd;
    logic [31:0]   q_word [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic          push;
    logic          pop;

    // A redirect cancels both queue operations in its cycle; words acked while discarding are dropped.
    assign instr_valid = (count != '0);
    assign push        = (state == WAIT) && imem_ack && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;

    // Occupancy after this cycle's push/pop, ignoring a flush.
    always_comb begin
        cnt_upd = count;
        if (push && !pop) begin
            cnt_upd = count + CW'(1);
        end else if (!push && pop) begin
            cnt_upd = count - CW'(1);
        end
    end

    // Next fetch state and PC; redirect overrides everything, and the low address bits are forced to zero.
    always_comb begin
        nxt_state = state;
        nxt_pc    = fetch_pc;
        if (redirect) begin
            nxt_pc = redirect_pc & ~32'h3;
            case (state)
                IDLE:    nxt_state = WAIT;
                WAIT:    nxt_state = imem_ack ? WAIT : DISCARD;
                DISCARD: nxt_state = imem_ack ? WAIT : DISCARD;
                default: nxt_state = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    // Entering WAIT reserves a slot for the word about to be requested.
                    if (count < FULL) begin
                        nxt_state = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        nxt_pc    = fetch_pc + 32'd4;
                        nxt_state = (cnt_upd < FULL) ? WAIT : IDLE;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        nxt_state = WAIT;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Fetch FSM with registered request outputs; the stale address is held through DISCARD until its ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= nxt_state;
            fetch_pc  <= nxt_pc;
            imem_req  <= (nxt_state != IDLE);
            if (nxt_state != DISCARD) begin
                imem_addr <= nxt_pc;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= cnt_upd;
        end
    end

    // Queue storage: each entry holds the fetched word and the address it came from.
    always_ff @(posedge clk) begin
        if (push) begin
            q_word[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= imem_addr;
        end
    end

    // Show-ahead head, zeroed while the queue is empty.
    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (instr_valid) begin
            instr    = q_word[rd_ptr];
            instr_pc = q_pc[rd_ptr];
        end
    end

    assign cond  = instr[31:28];
    assign op    = instr[27:26];
    assign funct = instr[25:20];
    assign rd    = instr[15:12];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: one DUT cycle per step; outputs sampled on the falling edge or 1ns after the rising edge.
// Backpressure: ack, ready and redirect are driven randomly or per scenario.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .cond        (cond),
        .op          (op),
        .funct       (funct),
        .rd          (rd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory returns address ^ mem_key for every fetch.
    logic [31:0] mem_key;

    // Reference model: expected queue contents and the next address the fetch stream should deliver.
    logic [31:0] mq_word [$];
    logic [31:0] mq_pc   [$];
    logic [31:0] exp_pc;
    bit          stale;
    bit          p_req;
    bit          p_ack;
    bit          p_room;
    logic [31:0] p_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        mq_word.delete();
        mq_pc.delete();
        exp_pc = RESET_PC;
        stale  = 1'b0;
        p_req  = 1'b0;
        p_ack  = 1'b0;
        p_room = 1'b0;
        p_addr = RESET_PC;
    endtask

    // Assert reset (asynchronously), check the reset values, release just after a rising edge.
    task automatic do_reset();
        reset       = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_rdata  = '0;
        #2;
        chk("rst_req",    32'(imem_req), 32'd0);
        chk("rst_valid",  32'(instr_valid), 32'd0);
        chk("rst_addr",   imem_addr, RESET_PC);
        chk("rst_instr",  instr, 32'd0);
        chk("rst_pc",     instr_pc, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    // One cycle: drive inputs, check outputs against the model at the falling edge, advance the model.
    task automatic step(input bit ack, input bit rdy, input bit redir, input logic [31:0] rpc);
        logic [31:0] w;
        bit          popped;
        int          sz;
        imem_ack    = ack;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_rdata  = imem_addr ^ mem_key;
        @(negedge clk);
        sz = mq_word.size();
        chk("valid", 32'(instr_valid), 32'(sz != 0));
        if (sz != 0) begin
            w = mq_word[0];
            chk("head_instr", instr, w);
            chk("head_pc",    instr_pc, mq_pc[0]);
            chk("cond",       32'(cond),  32'(w[31:28]));
            chk("op",         32'(op),    32'(w[27:26]));
            chk("funct",      32'(funct), 32'(w[25:20]));
            chk("rd",         32'(rd),    32'(w[15:12]));
        end else begin
            chk("empty_instr",  instr, 32'd0);
            chk("empty_pc",     instr_pc, 32'd0);
            chk("empty_fields", 32'({cond, op, funct, rd}), 32'd0);
        end
        if (sz == DEPTH) begin
            chk("req_when_full", 32'(imem_req), 32'd0);
        end
        if (p_req && !p_ack) begin
            chk("req_hold",  32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, p_addr);
        end
        if (!p_req && p_room) begin
            chk("req_rise", 32'(imem_req), 32'd1);
        end
        if (imem_req && !stale) begin
            chk("req_addr", imem_addr, exp_pc);
        end

        popped = (sz != 0) && rdy && !redir;
        p_room = (sz < DEPTH) || redir;
        p_req  = imem_req;
        p_ack  = ack;
        p_addr = imem_addr;
        if (redir) begin
            mq_word.delete();
            mq_pc.delete();
            stale  = imem_req && !ack;
            exp_pc = rpc & ~32'h3;
        end else begin
            if (popped) begin
                void'(mq_word.pop_front());
                void'(mq_pc.pop_front());
            end
            if (imem_req && ack) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    mq_word.push_back(exp_pc ^ mem_key);
                    mq_pc.push_back(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Streaming: one word per cycle, no bubbles.
        mem_key = 32'hE000_0000;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                chk("t1_idle_req", 32'(imem_req), 32'd0);
            end else begin
                chk("t1_req",  32'(imem_req), 32'd1);
                chk("t1_addr", imem_addr, 32'((i - 1) * 4));
            end
            if (i >= 2) begin
                chk("t1_valid", 32'(instr_valid), 32'd1);
                chk("t1_pc",    instr_pc, 32'((i - 2) * 4));
                chk("t1_instr", instr, 32'((i - 2) * 4) ^ 32'hE000_0000);
            end else begin
                chk("t1_valid_lo", 32'(instr_valid), 32'd0);
            end
            step(1'b1, 1'b1, 1'b0, 32'd0);
        end

        // Fill to DEPTH with the consumer stalled, then a single pop re-opens fetch at 0x10.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("t2_req_full", 32'(imem_req), 32'd0);
        chk("t2_head_pc",  instr_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t2_req_again", 32'(imem_req), 32'd1);
        chk("t2_addr_10",   imem_addr, 32'h10);
        chk("t2_head_pc4",  instr_pc, 32'h4);

        // Field split visible together with instr_valid.
        mem_key = 32'hE3A0_1005;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("t3_valid", 32'(instr_valid), 32'd1);
        chk("t3_cond",  32'(cond),  32'hE);
        chk("t3_op",    32'(op),    32'h0);
        chk("t3_funct", 32'(funct), 32'h3A);
        chk("t3_rd",    32'(rd),    32'h1);

        // Redirect while the request for 0x8 is outstanding: the late word is dropped.
        mem_key = 32'hE000_0000;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("t4_addr_8", imem_addr, 32'h8);
        step(1'b0, 1'b0, 1'b1, 32'h103);
        for (int i = 0; i < 2; i++) begin
            chk("t4_hold_req",  32'(imem_req), 32'd1);
            chk("t4_hold_addr", imem_addr, 32'h8);
            chk("t4_flushed",   32'(instr_valid), 32'd0);
            step(1'b0, 1'b0, 1'b0, 32'd0);
        end
        chk("t4_hold_addr_last", imem_addr, 32'h8);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("t4_new_addr", imem_addr, 32'h100);
        chk("t4_dropped",  32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("t4_new_valid", 32'(instr_valid), 32'd1);
        chk("t4_new_pc",    instr_pc, 32'h100);

        // Redirect colliding with pop and ack while two entries are queued.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("t5_head_pc", instr_pc, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h200);
        chk("t5_empty", 32'(instr_valid), 32'd0);
        chk("t5_req",   32'(imem_req), 32'd1);
        chk("t5_addr",  imem_addr, 32'h200);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t5_pc",    instr_pc, 32'h200);
        chk("t5_instr", instr, 32'h200 ^ 32'hE000_0000);

        // Reset in the middle of a request; a late ack after release is ignored.
        chk("t6_req_before", 32'(imem_req), 32'd1);
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("t6_first_req",  32'(imem_req), 32'd1);
        chk("t6_first_addr", imem_addr, RESET_PC);
        chk("t6_late_ack",   32'(instr_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("t6_no_push", 32'(instr_valid), 32'd0);

        // Fetch PC wraps past the top of the address space.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9);
        chk("wrap_f8", imem_addr, 32'hFFFF_FFF8);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("wrap_fc", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("wrap_0",  imem_addr, 32'h0);
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);

        // Randomized traffic with varying ack and consumer rates plus occasional redirects.
        mem_key = $urandom;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit a;
            bit r;
            bit rr;
            int ack_pct;
            int rdy_pct;
            ack_pct = ((i % 1000) < 500) ? 80 : 35;
            rdy_pct = ((i % 600) < 300) ? 25 : 90;
            a  = ($urandom_range(0, 99) < ack_pct);
            r  = ($urandom_range(0, 99) < rdy_pct);
            rr = ($urandom_range(0, 99) < 3);
            step(a, r, rr, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
